spi_burst_decoder: RTL and testbench
====================================

// Module: spi_burst_decoder
// PURPOSE
//  Parametrised successor to the single-access SPI instruction decoder. It sits between the SPI slave
//  (byte_sync/data_in/data_out) and the register file. Decodes a header byte and then services
//  one access, or a burst with address auto-increment, for as long as the frame stays active.
//  Register accesses use a strobe/ack handshake, so slow register banks can insert wait states.
//  Out-of-range addresses and byte overruns are reported through sticky error flags.
// PARAMETERS
//  ADDR_W     6     register address width (1..6); header bits [5:0] carry the start address
//  REG_COUNT  64    number of implemented registers; addresses >= REG_COUNT are out-of-range
//  RD_FILL    8'hFF data_out value returned for an out-of-range read
// PORTS
//  clk          in   1       peripheral clock
//  rst_n        in   1       reset, asynchronous, active-low
//  cs_active    in   1       SPI frame active (chip select asserted), synchronous to clk
//  byte_sync    in   1       1-cycle pulse: data_in holds a complete received byte
//  data_in      in   8       received byte
//  data_out     out  8       byte to shift out on the next SPI byte
//  reg_read     out  1       read strobe, held until reg_ack
//  reg_write    out  1       write strobe, held until reg_ack
//  reg_addr     out  ADDR_W  register address, stable while a strobe is high
//  reg_wdata    out  8       write data, stable while reg_write is high
//  reg_rdata    in   8       read data, sampled in the cycle reg_ack is high
//  reg_ack      in   1       access complete; may be high in the first strobe cycle
//  busy         out  1       high in any state other than IDLE
//  err_addr     out  1       sticky: an out-of-range access was suppressed
//  err_overrun  out  1       sticky: byte_sync arrived while an access was pending
//  err_clr      in   1       synchronous clear of both sticky flags
// BEHAVIOUR
//  Reset: state=IDLE. All outputs are 0 (data_out=0, reg_addr=0, reg_wdata=0, flags=0).
//  Header byte: [7] rw (1=write), [6] burst, [5:0] start address.
//    Header bits above ADDR_W-1 must be 0; if not, the address is treated as out-of-range.
//  FSM states: IDLE, WR_DATA, WR_ACC, RD_ACC, RD_WAIT.
//   IDLE: byte_sync with cs_active -> latch header. Write -> WR_DATA. Read -> RD_ACC.
//     For a read, reg_read is asserted one cycle after the header byte_sync.
//   WR_DATA: byte_sync -> reg_wdata<=data_in, then WR_ACC; reg_write rises the next cycle.
//   WR_ACC: hold reg_write until reg_ack; it deasserts the cycle after ack.
//     After ack: burst -> address+1 and go to WR_DATA; otherwise go to IDLE.
//   RD_ACC: hold reg_read until reg_ack. On ack, data_out<=reg_rdata, then RD_WAIT.
//   RD_WAIT: byte_sync (dummy/next byte) ends the current read.
//     Burst -> address+1 and go to RD_ACC (prefetch the next register); otherwise go to IDLE.
//  Address increment wraps REG_COUNT-1 -> 0 (mod REG_COUNT).
//  Out-of-range access: no strobe is issued; the access completes internally in 1 cycle.
//    err_addr is set. A read loads RD_FILL into data_out.
//  cs_active low:
//    in IDLE/WR_DATA/RD_WAIT -> go to IDLE the next cycle.
//    in WR_ACC/RD_ACC -> complete the pending access (wait for ack), then IDLE.
//    A strobe is never truncated.
//  byte_sync while in WR_ACC/RD_ACC: the byte is dropped, err_overrun is set, state is unchanged.
//  byte_sync with cs_active low is ignored.
//  err_clr in the same cycle as a new error event: the set wins.
//  reg_read and reg_write are never high together. busy=0 only in IDLE.
//  No combinational path from any input to any output.
// STRUCTURE
//  Package spi_burst_pkg holds: state enum (3-bit), header field positions (HDR_RW=7, HDR_BURST=6,
//    HDR_ADDR_MSB=5), RD_FILL default.
//  Sub-module burst_addr_ctr (load, inc, wrap at REG_COUNT, range check) -> instantiate once.
// TESTING
//  Single write: header 8'h85, data 8'h3C, ack after 2 cycles -> one reg_write pulse, 3 cycles long.
//    reg_addr=5, reg_wdata=8'h3C; then IDLE with busy=0.
//  Burst read: header 8'h7E, REG_COUNT=64, three dummy bytes -> reads at addresses 62, 63, 0, 1.
//    data_out tracks reg_rdata of each read in turn; the wrap from 63 to 0 is verified.
//  Out-of-range: REG_COUNT=40, header 8'h30 (read, address 48) -> no reg_read.
//    data_out=8'hFF, err_addr=1; err_clr clears it.
//  Overrun: burst write with reg_ack held low 20 cycles and a second byte_sync during the wait.
//    The byte is dropped, err_overrun=1, and only the first write completes.
//  cs_active drops mid-WR_ACC: reg_write stays high until ack, then IDLE.
//    A following header is decoded normally.
//  Async reset asserted mid-burst -> all outputs are 0 in the same cycle; IDLE after release.

Source files
------------

// File: rtl/spi_burst_pkg.sv
// Shared types and header field positions for the SPI burst instruction decoder.
package spi_burst_pkg;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_DATA = 3'd1,
    ST_WR_ACC  = 3'd2,
    ST_RD_ACC  = 3'd3,
    ST_RD_WAIT = 3'd4
  } state_e;

  localparam int HDR_RW       = 7;
  localparam int HDR_BURST    = 6;
  localparam int HDR_ADDR_MSB = 5;

  localparam logic [7:0] RD_FILL_DEF = 8'hFF;
endpackage

// File: rtl/burst_addr_ctr.sv
// Burst address register: loads the header address, auto-increments with wrap at
// REG_COUNT, and reports whether the current address maps to an implemented register.
module burst_addr_ctr
  import spi_burst_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int REG_COUNT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [HDR_ADDR_MSB:0] load_addr_i,
  input  logic                  inc_i,
  output logic [ADDR_W-1:0]     addr_o,
  output logic                  in_range_o
);
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hi_bad_q, hi_bad_d;
  logic              hdr_hi_bad;

  // Header address bits beyond ADDR_W must be zero or the whole burst is out of range.
  generate
    if (ADDR_W < HDR_ADDR_MSB + 1) begin : g_hi
      assign hdr_hi_bad = |load_addr_i[HDR_ADDR_MSB:ADDR_W];
    end else begin : g_nohi
      assign hdr_hi_bad = 1'b0;
    end
  endgenerate

  always_comb begin
    addr_d   = addr_q;
    hi_bad_d = hi_bad_q;
    if (load_i) begin
      addr_d   = load_addr_i[ADDR_W-1:0];
      hi_bad_d = hdr_hi_bad;
    end else if (inc_i) begin
      addr_d = (32'(addr_q) == REG_COUNT - 1) ? '0 : addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      hi_bad_q <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      hi_bad_q <= hi_bad_d;
    end
  end

  assign addr_o     = addr_q;
  assign in_range_o = !hi_bad_q && (32'(addr_q) < REG_COUNT);
endmodule

// File: rtl/spi_burst_decoder.sv
// SPI header/burst decoder bridging the SPI slave byte stream to a strobe/ack register bank.
// All outputs come straight from registers; strobes are decoded from the state register only.
module spi_burst_decoder
  import spi_burst_pkg::*;
#(
  parameter int         ADDR_W    = 6,
  parameter int         REG_COUNT = 64,
  parameter logic [7:0] RD_FILL   = RD_FILL_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_active,
  input  logic              byte_sync,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              reg_read,
  output logic              reg_write,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  input  logic [7:0]        reg_rdata,
  input  logic              reg_ack,
  output logic              busy,
  output logic              err_addr,
  output logic              err_overrun,
  input  logic              err_clr
);
  state_e     state_q, state_d;
  logic       burst_q, burst_d;
  logic [7:0] dout_q, dout_d;
  logic [7:0] wdata_q, wdata_d;
  logic       err_addr_q, err_addr_d;
  logic       err_ovr_q, err_ovr_d;
  logic       ctr_load, ctr_inc, in_range;
  logic       addr_set, ovr_set, acc_done, bs_v;

  burst_addr_ctr #(.ADDR_W(ADDR_W), .REG_COUNT(REG_COUNT)) u_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ctr_load),
    .load_addr_i(data_in[HDR_ADDR_MSB:0]),
    .inc_i      (ctr_inc),
    .addr_o     (reg_addr),
    .in_range_o (in_range)
  );

  assign bs_v = byte_sync & cs_active;
  // Suppressed (out-of-range) accesses finish on their own in one cycle.
  assign acc_done = in_range ? reg_ack : 1'b1;

  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    dout_d   = dout_q;
    wdata_d  = wdata_q;
    ctr_load = 1'b0;
    ctr_inc  = 1'b0;
    addr_set = 1'b0;
    ovr_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bs_v) begin
          ctr_load = 1'b1;
          burst_d  = data_in[HDR_BURST];
          state_d  = data_in[HDR_RW] ? ST_WR_DATA : ST_RD_ACC;
        end
      end
      ST_WR_DATA: begin
        if (!cs_active) begin
          state_d = ST_IDLE;
        end else if (byte_sync) begin
          wdata_d = data_in;
          state_d = ST_WR_ACC;
        end
      end
      ST_WR_ACC: begin
        ovr_set = bs_v;
        if (acc_done) begin
          addr_set = !in_range;
          if (burst_q && cs_active) begin
            ctr_inc = 1'b1;
            state_d = ST_WR_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RD_ACC: begin
        ovr_set = bs_v;
        if (acc_done) begin
          addr_set = !in_range;
          dout_d   = in_range ? reg_rdata : RD_FILL;
          state_d  = cs_active ? ST_RD_WAIT : ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (!cs_active) begin
          state_d = ST_IDLE;
        end else if (byte_sync) begin
          if (burst_q) begin
            ctr_inc = 1'b1;
            state_d = ST_RD_ACC;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A new error event outranks a simultaneous clear.
    err_addr_d = addr_set | (err_addr_q & ~err_clr);
    err_ovr_d  = ovr_set  | (err_ovr_q  & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      burst_q    <= 1'b0;
      dout_q     <= '0;
      wdata_q    <= '0;
      err_addr_q <= 1'b0;
      err_ovr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      dout_q     <= dout_d;
      wdata_q    <= wdata_d;
      err_addr_q <= err_addr_d;
      err_ovr_q  <= err_ovr_d;
    end
  end

  assign reg_read    = (state_q == ST_RD_ACC) && in_range;
  assign reg_write   = (state_q == ST_WR_ACC) && in_range;
  assign busy        = (state_q != ST_IDLE);
  assign data_out    = dout_q;
  assign reg_wdata   = wdata_q;
  assign err_addr    = err_addr_q;
  assign err_overrun = err_ovr_q;
endmodule

// File: tb/tb_spi_burst_decoder.sv
// Scoreboard bench: frame-level reference model pushes expected register accesses and
// shifted-out bytes; a negedge monitor pops them as the decoder presents them.
module tb_spi_burst_decoder;
  localparam int REG_N = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       cs_active, byte_sync, err_clr, reg_ack;
  logic [7:0] data_in, reg_rdata, data_out, reg_wdata;
  logic       reg_read, reg_write, busy, err_addr, err_overrun;
  logic [5:0] reg_addr;

  spi_burst_decoder dut (
    .clk(clk), .rst_n(rst_n), .cs_active(cs_active), .byte_sync(byte_sync),
    .data_in(data_in), .data_out(data_out), .reg_read(reg_read), .reg_write(reg_write),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
    .busy(busy), .err_addr(err_addr), .err_overrun(err_overrun), .err_clr(err_clr)
  );

  // Second instance with a partially populated register bank, answering every strobe at once.
  logic       b_cs, b_bs, b_clr, b_rd, b_wr, b_busy, b_eaddr, b_eovr;
  logic [7:0] b_din, b_dout, b_wdata;
  logic [7:0] b_rdata = 8'h3D;
  logic [5:0] b_addr;
  logic       b_ack;
  assign b_ack = b_rd | b_wr;

  spi_burst_decoder #(.ADDR_W(6), .REG_COUNT(40), .RD_FILL(8'hFF)) dut40 (
    .clk(clk), .rst_n(rst_n), .cs_active(b_cs), .byte_sync(b_bs),
    .data_in(b_din), .data_out(b_dout), .reg_read(b_rd), .reg_write(b_wr),
    .reg_addr(b_addr), .reg_wdata(b_wdata), .reg_rdata(b_rdata), .reg_ack(b_ack),
    .busy(b_busy), .err_addr(b_eaddr), .err_overrun(b_eovr), .err_clr(b_clr)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Register bank model with configurable wait states (-1 = random 0..3).
  logic [7:0] mem [REG_N];
  logic [7:0] mdl_mem [REG_N];
  int ack_dly = -1;
  int cur_dly = 0;
  int cnt = 0;

  initial begin
    reg_ack = 1'b0;
    reg_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        reg_ack = 1'b0;
        cnt = 0;
      end else if ((reg_read || reg_write) && !reg_ack) begin
        if (cnt == 0) cur_dly = (ack_dly < 0) ? int'($urandom_range(0, 3)) : ack_dly;
        if (cnt >= cur_dly) begin
          reg_ack = 1'b1;
          reg_rdata = mem[reg_addr];
          if (reg_write) mem[reg_addr] = reg_wdata;
        end else begin
          cnt++;
        end
      end else begin
        reg_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  typedef struct {
    bit         wr;
    logic [5:0] addr;
    logic [7:0] data;
  } acc_t;

  acc_t       exp_acc [$];
  logic [7:0] exp_dout [$];
  acc_t       mon_e;
  logic [7:0] mon_d;
  logic       dout_chk = 1'b0;
  int         wr_len = 0;
  int         last_wr_len = 0;
  int         b_rd_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_read || reg_write) chk("strobe_excl", {31'b0, reg_read & reg_write}, 0);
      if ((reg_read || reg_write) && reg_ack) begin
        if (exp_acc.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL acc_unexpected: got wr=%0b addr=%0d, none expected", reg_write, reg_addr);
        end else begin
          mon_e = exp_acc.pop_front();
          chk("acc_rw", {31'b0, reg_write}, {31'b0, mon_e.wr});
          chk("acc_addr", {26'b0, reg_addr}, {26'b0, mon_e.addr});
          if (mon_e.wr) chk("acc_wdata", {24'b0, reg_wdata}, {24'b0, mon_e.data});
        end
      end
      if (byte_sync && dout_chk) begin
        if (exp_dout.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL dout_unexpected: got %0h, none expected", data_out);
        end else begin
          mon_d = exp_dout.pop_front();
          chk("data_out", {24'b0, data_out}, {24'b0, mon_d});
        end
      end
      if (reg_write) wr_len++;
      else if (wr_len != 0) begin
        last_wr_len = wr_len;
        wr_len = 0;
      end
      if (b_rd) b_rd_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic cd, input int gap);
    @(posedge clk); #1;
    byte_sync = 1'b1;
    data_in = b;
    dout_chk = cd;
    @(posedge clk); #1;
    byte_sync = 1'b0;
    dout_chk = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic send_b(input logic [7:0] b);
    @(posedge clk); #1;
    b_bs = 1'b1;
    b_din = b;
    @(posedge clk); #1;
    b_bs = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    chk(nm, {31'b0, busy}, 0);
  endtask

  // Frame-level model: derives every access and shifted-out byte from the header rules.
  task automatic frame(input bit wr, input bit burst, input logic [5:0] a, input int n);
    logic [5:0] ad;
    logic [7:0] d;
    cs_active = 1'b1;
    if (!wr) exp_acc.push_back('{1'b0, a, 8'h00});
    send_byte({wr, burst, a}, 1'b0, 8);
    for (int i = 0; i < n; i++) begin
      ad = 6'((int'(a) + i) % REG_N);
      if (wr) begin
        d = 8'($urandom);
        exp_acc.push_back('{1'b1, ad, d});
        mdl_mem[ad] = d;
        send_byte(d, 1'b0, 8);
      end else begin
        exp_dout.push_back(mdl_mem[ad]);
        if (burst) exp_acc.push_back('{1'b0, 6'((int'(a) + i + 1) % REG_N), 8'h00});
        send_byte(8'($urandom), 1'b1, 8);
      end
    end
    repeat (4) @(posedge clk);
    #1 cs_active = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("frame_idle", {31'b0, busy}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    cs_active = 0; byte_sync = 0; data_in = 0; err_clr = 0;
    b_cs = 0; b_bs = 0; b_din = 0; b_clr = 0;
    for (int i = 0; i < REG_N; i++) begin
      mem[i] = 8'((i * 37 + 5) & 8'hFF);
      mdl_mem[i] = 8'((i * 37 + 5) & 8'hFF);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", {24'b0, data_out}, 0);
    chk("rst_strobes", {30'b0, reg_read, reg_write}, 0);
    chk("rst_addr", {26'b0, reg_addr}, 0);
    chk("rst_wdata", {24'b0, reg_wdata}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_flags", {30'b0, err_addr, err_overrun}, 0);
    chk("rst_b_wdata", {24'b0, b_wdata}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single write, ack after 2 wait cycles.
    ack_dly = 2;
    cs_active = 1'b1;
    exp_acc.push_back('{1'b1, 6'd5, 8'h3C});
    mdl_mem[5] = 8'h3C;
    send_byte(8'h85, 1'b0, 8);
    send_byte(8'h3C, 1'b0, 8);
    chk("wr_pulse_len", last_wr_len, 3);
    chk("wr_idle", {31'b0, busy}, 0);
    cs_active = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Burst read across the 63 -> 0 wrap.
    ack_dly = -1;
    frame(1'b0, 1'b1, 6'd62, 3);

    // Overrun: second byte during a long access, with a coincident clear.
    ack_dly = 20;
    cs_active = 1'b1;
    exp_acc.push_back('{1'b1, 6'd4, 8'hA5});
    mdl_mem[4] = 8'hA5;
    send_byte(8'hC4, 1'b0, 8);
    send_byte(8'hA5, 1'b0, 3);
    @(posedge clk); #1;
    byte_sync = 1'b1; data_in = 8'h66; err_clr = 1'b1;
    @(posedge clk); #1;
    byte_sync = 1'b0; err_clr = 1'b0;
    chk("ovr_set", {31'b0, err_overrun}, 1);
    repeat (25) @(posedge clk);
    #1;
    chk("ovr_single_write", exp_acc.size(), 0);
    cs_active = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("ovr_idle", {31'b0, busy}, 0);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("ovr_clr", {31'b0, err_overrun}, 0);

    // Chip select drops while the write strobe is pending.
    ack_dly = 6;
    cs_active = 1'b1;
    exp_acc.push_back('{1'b1, 6'd10, 8'h5A});
    mdl_mem[10] = 8'h5A;
    send_byte(8'h8A, 1'b0, 8);
    send_byte(8'h5A, 1'b0, 2);
    cs_active = 1'b0;
    @(negedge clk);
    chk("csdrop_hold", {31'b0, reg_write}, 1);
    @(posedge clk); #1;
    wait_idle("csdrop_idle", 30);
    repeat (2) @(posedge clk);
    #1;
    ack_dly = -1;
    frame(1'b0, 1'b0, 6'd10, 1);

    // Asynchronous reset in the middle of a burst read.
    ack_dly = 20;
    cs_active = 1'b1;
    send_byte(8'h48, 1'b0, 3);
    chk("pre_rst_read", {31'b0, reg_read}, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_read", {31'b0, reg_read}, 0);
    chk("arst_dout", {24'b0, data_out}, 0);
    chk("arst_addr", {26'b0, reg_addr}, 0);
    chk("arst_busy", {31'b0, busy}, 0);
    exp_acc.delete();
    exp_dout.delete();
    cs_active = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ack_dly = -1;
    @(posedge clk); #1;
    chk("post_rst_idle", {31'b0, busy}, 0);
    frame(1'b0, 1'b1, 6'd20, 2);

    // Out-of-range read and last implemented register on the 40-entry bank.
    b_cs = 1'b1;
    b_rd_cnt = 0;
    send_b(8'h30);
    chk("oor_no_read", b_rd_cnt, 0);
    chk("oor_fill", {24'b0, b_dout}, 32'hFF);
    chk("oor_err", {31'b0, b_eaddr}, 1);
    send_b(8'h00);
    chk("oor_idle", {31'b0, b_busy}, 0);
    @(posedge clk); #1 b_clr = 1'b1;
    @(posedge clk); #1 b_clr = 1'b0;
    chk("oor_clr", {31'b0, b_eaddr}, 0);
    send_b(8'h27);
    chk("edge_read_once", b_rd_cnt, 1);
    chk("edge_addr", {26'b0, b_addr}, 39);
    chk("edge_dout", {24'b0, b_dout}, 32'h3D);
    chk("edge_no_err", {31'b0, b_eaddr}, 0);
    send_b(8'h00);
    b_cs = 1'b0;
    chk("b_no_ovr", {31'b0, b_eovr}, 0);

    // Randomized frames against the frame-level model.
    for (int f = 0; f < 40; f++) begin
      bit w, bu;
      w = 1'($urandom);
      bu = 1'($urandom);
      frame(w, bu, 6'($urandom), bu ? int'($urandom_range(1, 4)) : 1);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("acc_queue_empty", exp_acc.size(), 0);
    chk("dout_queue_empty", exp_dout.size(), 0);
    chk("final_flags", {30'b0, err_addr, err_overrun}, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
